nx_indirect_access_initiator: RTL and testbench

//  Command-side master for the nx indirect-access register protocol. Accepts one memory op
//  (READ/WRITE/INIT) on a valid/ready request port, drives the target's register strobes
//  (data then command), polls stat_code until not BUSY and returns status plus read data.

---
 rtl/nx_indirect_access_initiator_if.sv | 31 +++
 rtl/nx_indirect_access_initiator.sv | 122 ++++++++++++
 tb/tb_nx_indirect_access_initiator.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nx_indirect_access_initiator_if.sv
// nx_indirect_access_initiator_if: request/response port plus target register strobe bus
interface nx_indirect_access_initiator_if #(
    parameter int N_REG_ADDR_BITS = 11,
    parameter int N_ADDR_BITS     = 14,
    parameter int N_DATA_BITS     = 38
);
    logic                       req_valid;
    logic                       req_ready;
    logic [3:0]                 req_op;
    logic [N_ADDR_BITS-1:0]     req_addr;
    logic [N_DATA_BITS-1:0]     req_wdata;
    logic                       rsp_valid;
    logic [2:0]                 rsp_status;
    logic [N_DATA_BITS-1:0]     rsp_rdata;
    logic                       wr_stb;
    logic [N_REG_ADDR_BITS-1:0] reg_addr;
    logic [3:0]                 cmnd_op;
    logic [N_ADDR_BITS-1:0]     cmnd_addr;
    logic [N_DATA_BITS-1:0]     wr_dat;
    logic [2:0]                 stat_code;
    logic [N_DATA_BITS-1:0]     rd_dat;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, stat_code, rd_dat,
        output req_ready, rsp_valid, rsp_status, rsp_rdata, wr_stb, reg_addr, cmnd_op, cmnd_addr, wr_dat
    );
    modport slave (
        output req_valid, req_op, req_addr, req_wdata, stat_code, rd_dat,
        input  req_ready, rsp_valid, rsp_status, rsp_rdata, wr_stb, reg_addr, cmnd_op, cmnd_addr, wr_dat
    );
endinterface

// File: rtl/nx_indirect_access_initiator.sv
// nx_indirect_access_initiator: drives one READ/WRITE/INIT through the indirect register protocol
module nx_indirect_access_initiator #(
    parameter int                         N_REG_ADDR_BITS = 11,
    parameter int                         N_ADDR_BITS     = 14,
    parameter int                         N_DATA_BITS     = 38,
    parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS    = 11'h1B8,
    parameter logic [N_REG_ADDR_BITS-1:0] DATA_ADDRESS    = 11'h1B0,
    parameter int                         SETTLE_CYCLES   = 2,
    parameter int                         TMO_LIMIT       = 1023
) (
    input logic clk,
    input logic rst_n,
    nx_indirect_access_initiator_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_DATA = 3'd1;
    localparam logic [2:0] WR_CMND = 3'd2;
    localparam logic [2:0] SETTLE  = 3'd3;
    localparam logic [2:0] POLL    = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    localparam logic [3:0] OP_READ  = 4'd1;
    localparam logic [3:0] OP_WRITE = 4'd2;
    localparam logic [3:0] OP_INIT  = 4'd6;

    localparam logic [2:0] ST_RDY = 3'd0;
    localparam logic [2:0] ST_BSY = 3'd1;
    localparam logic [2:0] ST_TMO = 3'd2;
    localparam logic [2:0] ST_ERR = 3'd7;

    localparam int              SW          = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [9:0]      TMO_LAST    = 10'(TMO_LIMIT - 1);

    logic [2:0]             state;
    logic [3:0]             op;
    logic [N_ADDR_BITS-1:0] addr;
    logic [N_DATA_BITS-1:0] wdata;
    logic [SW-1:0]          settle_cnt;
    logic [9:0]             poll_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op             <= '0;
            addr           <= '0;
            wdata          <= '0;
            settle_cnt     <= '0;
            poll_cnt       <= '0;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_status <= '0;
            bus.rsp_rdata  <= '0;
            bus.wr_stb     <= 1'b0;
            bus.reg_addr   <= '0;
            bus.cmnd_op    <= '0;
            bus.cmnd_addr  <= '0;
            bus.wr_dat     <= '0;
        end else begin
            bus.wr_stb    <= 1'b0;
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid && bus.req_ready) begin
                    op            <= bus.req_op;
                    addr          <= bus.req_addr;
                    wdata         <= bus.req_wdata;
                    settle_cnt    <= '0;
                    poll_cnt      <= '0;
                    bus.req_ready <= 1'b0;
                    if (bus.req_op == OP_WRITE) begin
                        state        <= WR_DATA;
                        bus.wr_stb   <= 1'b1;
                        bus.reg_addr <= DATA_ADDRESS;
                        bus.wr_dat   <= bus.req_wdata;
                    end else if (bus.req_op == OP_READ || bus.req_op == OP_INIT) begin
                        state         <= WR_CMND;
                        bus.wr_stb    <= 1'b1;
                        bus.reg_addr  <= CMND_ADDRESS;
                        bus.cmnd_op   <= bus.req_op;
                        bus.cmnd_addr <= bus.req_addr;
                    end else begin
                        state          <= RESP;
                        bus.rsp_status <= ST_ERR;
                        bus.rsp_rdata  <= '0;
                    end
                end
                WR_DATA: begin
                    state         <= WR_CMND;
                    bus.wr_stb    <= 1'b1;
                    bus.reg_addr  <= CMND_ADDRESS;
                    bus.cmnd_op   <= op;
                    bus.cmnd_addr <= addr;
                end
                WR_CMND: state <= SETTLE;
                SETTLE: if (settle_cnt == SETTLE_LAST) state <= POLL;
                        else settle_cnt <= settle_cnt + 1'b1;
                // The target's verdict is registered together with the RESP entry so the pulse lands one cycle later
                POLL: if (bus.stat_code != ST_BSY) begin
                    state          <= RESP;
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_status <= bus.stat_code;
                    bus.rsp_rdata  <= (op == OP_READ && bus.stat_code == ST_RDY) ? bus.rd_dat : '0;
                end else if (poll_cnt == TMO_LAST) begin
                    state          <= RESP;
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_status <= ST_TMO;
                    bus.rsp_rdata  <= '0;
                end else begin
                    poll_cnt <= poll_cnt + 1'b1;
                end
                // A rejected op arrives here without the pulse pending, so it spends one extra cycle raising it
                RESP: if (bus.rsp_valid) begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end else begin
                    bus.rsp_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nx_indirect_access_initiator.sv
// tb_nx_indirect_access_initiator: directed scoreboard bench for the indirect-access initiator
module tb_nx_indirect_access_initiator;
    localparam logic [10:0] DATA_A = 11'h1B0;
    localparam logic [10:0] CMND_A = 11'h1B8;
    localparam int          TMO    = 1023;

    typedef struct {logic [2:0] st; logic [37:0] rd; int at;} rsp_t;
    typedef struct {logic [10:0] ra; logic [37:0] val;} stb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;
    rsp_t rsp_q[$];
    stb_t stb_q[$];
    rsp_t re;
    stb_t se;

    nx_indirect_access_initiator_if bus();
    nx_indirect_access_initiator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (bus.wr_stb) begin
            check("stb_expected", 64'(stb_q.size() != 0), 1);
            if (stb_q.size() != 0) begin
                se = stb_q.pop_front();
                check("stb_reg_addr", bus.reg_addr, se.ra);
                check("stb_value", se.ra == DATA_A ? bus.wr_dat : {20'b0, bus.cmnd_op, bus.cmnd_addr}, se.val);
            end
        end
        if (bus.rsp_valid) begin
            check("rsp_expected", 64'(rsp_q.size() != 0), 1);
            if (rsp_q.size() != 0) begin
                re = rsp_q.pop_front();
                check("rsp_status", bus.rsp_status, re.st);
                check("rsp_rdata", bus.rsp_rdata, re.rd);
                check("rsp_cycle", cyc, re.at);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [13:0] addr, input logic [37:0] wd,
                        input logic [2:0] fin, input int busy, input logic [2:0] est,
                        input logic [37:0] erd, input bit hold, output int acc);
        int  n = 0;
        bit  good = (op == 4'd1 || op == 4'd2 || op == 4'd6);
        int  base = op == 4'd2 ? 6 : good ? 5 : 2;
        if (op == 4'd2) stb_q.push_back('{DATA_A, wd});
        if (good) stb_q.push_back('{CMND_A, {20'b0, op, addr}});
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        while (!bus.req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_at_accept", bus.req_ready, 1);
        acc = cyc;
        rsp_q.push_back('{est, erd, cyc + base + busy});
        bus.stat_code = 3'd1;
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
        if (good) begin
            repeat (base - 2 + busy) @(negedge clk);
            bus.stat_code = fin;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (rsp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_drained", rsp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int a1, a2, d;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.stat_code = 3'd0;
        bus.rd_dat    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_status", bus.rsp_status, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_wr_stb", bus.wr_stb, 0);
        check("rst_reg_addr", bus.reg_addr, 0);
        check("rst_cmnd_op", bus.cmnd_op, 0);
        check("rst_cmnd_addr", bus.cmnd_addr, 0);
        check("rst_wr_dat", bus.wr_dat, 0);

        bus.rd_dat = 38'h15_5555_5555;
        send(4'd2, 14'h0012, 38'h3_0000_00AB, 3'd0, 0, 3'd0, 38'h0, 1'b0, d);
        drain();
        bus.rd_dat = 38'h2A;
        send(4'd1, 14'h3FFF, 38'h0, 3'd0, 5, 3'd0, 38'h2A, 1'b0, d);
        drain();
        bus.rd_dat = 38'h3F_0F0F_0F0F;
        send(4'd1, 14'h0005, 38'h0, 3'd1, TMO - 1, 3'd2, 38'h0, 1'b0, d);
        drain();
        send(4'd1, 14'h0777, 38'h0, 3'd3, 0, 3'd3, 38'h0, 1'b0, d);
        drain();
        send(4'hF, 14'h0001, 38'h1, 3'd0, 0, 3'd7, 38'h0, 1'b0, d);
        drain();
        send(4'd6, 14'h0100, 38'h0, 3'd0, 3, 3'd0, 38'h0, 1'b0, d);
        drain();
        send(4'd2, 14'h2AAA, 38'h2A_AAAA_AAAA, 3'd5, 1, 3'd5, 38'h0, 1'b0, d);
        drain();

        bus.rd_dat = 38'h3C;
        send(4'd2, 14'h0040, 38'h11, 3'd0, 0, 3'd0, 38'h0, 1'b1, a1);
        send(4'd1, 14'h0041, 38'h0, 3'd0, 0, 3'd0, 38'h3C, 1'b0, a2);
        check("b2b_accept_cycle", a2, a1 + 7);
        drain();

        send(4'd1, 14'h0099, 38'h0, 3'd1, 2, 3'd0, 38'h0, 1'b0, d);
        rsp_q.delete();
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_rsp_status", bus.rsp_status, 0);
        check("mid_rst_wr_stb", bus.wr_stb, 0);
        check("mid_rst_reg_addr", bus.reg_addr, 0);
        check("mid_rst_cmnd_op", bus.cmnd_op, 0);
        check("mid_rst_cmnd_addr", bus.cmnd_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", bus.req_ready, 1);
        repeat (20) @(negedge clk);

        bus.rd_dat = 38'h1234;
        send(4'd1, 14'h0002, 38'h0, 3'd0, 0, 3'd0, 38'h1234, 1'b0, d);
        drain();
        check("stb_q_empty", stb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
